serial_adder_ctrl: RTL and testbench

- Bit-serial N-bit add/subtract unit built around a single shared 1-bit full adder, which is instantiated once.
- Computes one bit per clock, LSB first.
- The controller handles the start/busy/done handshake, operand shift registers, the carry register and the result shift register.
- Sits beside the 1-bit full-adder datapath as its sequencer, so a multi-bit add costs one adder cell plus WIDTH cycles.

---
 rtl/serial_adder_ctrl_pkg.sv | 14 +
 rtl/serial_adder_ctrl_if.sv | 28 ++
 rtl/full_adder_bit.sv | 17 +
 rtl/serial_adder_ctrl.sv | 98 +++++++++
 tb/tb_serial_adder_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   WIDTH_DEF : default operand/result width
//   state_e   : sequencer state encoding
package serial_adder_ctrl_pkg;

   localparam int unsigned WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for the serial add/subtract unit.
//   master : drives start, sub, a, b; observes busy, done, sum, cout, ovf
//   slave  : the arithmetic unit side
interface serial_adder_ctrl_if #(
   parameter int unsigned WIDTH = serial_adder_ctrl_pkg::WIDTH_DEF
);

   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, cout, ovf
   );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder, the only arithmetic cell of the serial unit.
//   A, B : operand bits
//   C0   : carry in
//   F    : sum bit
//   C1   : carry out (majority of A, B, C0)
module full_adder_bit (
   input  logic A,
   input  logic B,
   input  logic C0,
   output logic F,
   output logic C1
);

   assign F  = A ^ B ^ C0;
   assign C1 = (A & B) | (A & C0) | (B & C0);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer around one shared full adder.
// One result bit per clock, LSB first; subtraction is A + ~B + 1.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of serial_adder_ctrl_if (start/sub/a/b in,
//              busy/done/sum/cout/ovf out)
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter  int unsigned WIDTH = WIDTH_DEF,
   localparam int unsigned CNT_W = $clog2(WIDTH)
) (
   input  logic                clk,
   input  logic                rst,
   serial_adder_ctrl_if.slave  bus
);

   state_e             state;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   sum_r;
   logic [CNT_W-1:0]   cnt;
   logic               carry;
   logic               cmsb;
   logic               cout_r;
   logic               ovf_r;
   logic               busy_r;
   logic               done_r;
   logic               fa_f;
   logic               fa_c1;

   full_adder_bit u_fa (
      .A  (op_a[0]),
      .B  (op_b[0]),
      .C0 (carry),
      .F  (fa_f),
      .C1 (fa_c1)
   );

   // Sequencer; busy/done are registered from the state and so trail it by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cmsb   <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state == ST_RUN) || (state == ST_DONE);
         done_r <= (state == ST_DONE);
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  op_a  <= bus.a;
                  op_b  <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub;
                  cnt   <= '0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum_r <= {fa_f, sum_r[WIDTH-1:1]};
               op_a  <= {1'b0, op_a[WIDTH-1:1]};
               op_b  <= {1'b0, op_b[WIDTH-1:1]};
               carry <= fa_c1;
               cnt   <= cnt + CNT_W'(1);
               // Carry into the MSB, needed for signed overflow.
               if (cnt == CNT_W'(WIDTH - 2)) begin
                  cmsb <= fa_c1;
               end
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  cout_r <= fa_c1;
                  ovf_r  <= fa_c1 ^ cmsb;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
   assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed + randomised self-checking bench for serial_adder_ctrl at WIDTH=8 and 13.
module tb_serial_adder_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   serial_adder_ctrl_if #(.WIDTH(8))  i8  ();
   serial_adder_ctrl_if #(.WIDTH(13)) i13 ();

   serial_adder_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(i8));
   serial_adder_ctrl #(.WIDTH(13)) u_dut13 (.clk(clk), .rst(rst), .bus(i13));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} of a +/- b at width w
   function automatic logic [33:0] model(input int w, input logic s,
                                         input logic [31:0] av, input logic [31:0] bv);
      logic [63:0] mask;
      logic [63:0] bb;
      logic [63:0] tot;
      logic [31:0] sm;
      logic        ov;
      mask = (64'd1 << w) - 64'd1;
      bb   = s ? (~{32'd0, bv} & mask) : ({32'd0, bv} & mask);
      tot  = ({32'd0, av} & mask) + bb + {63'd0, s};
      sm   = 32'(tot & mask);
      ov   = (av[w-1] == bb[w-1]) && (sm[w-1] != av[w-1]);
      return {ov, tot[w], sm};
   endfunction

   // One 8-bit op; lat = negedges after the accept edge until done is seen.
   // glitch_at >= 0 re-pulses start with a=b=0xFF during RUN.
   task automatic op8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input int glitch_at, output logic [7:0] rs, output logic rc,
                      output logic ro, output int lat, output int nbusy);
      int j;
      @(negedge clk);
      i8.start = 1'b1; i8.sub = s; i8.a = av; i8.b = bv;
      @(negedge clk);
      j = 0; nbusy = 0;
      while (!i8.done && j < 40) begin
         if (j == glitch_at) begin
            i8.start = 1'b1; i8.a = 8'hFF; i8.b = 8'hFF;
         end else begin
            i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
            i8.sub = 1'($urandom);
         end
         @(negedge clk);
         j++;
         if (i8.busy) nbusy++;
      end
      i8.start = 1'b0;
      lat = j; rs = i8.sum; rc = i8.cout; ro = i8.ovf;
   endtask

   task automatic op13(input logic s, input logic [12:0] av, input logic [12:0] bv,
                       output logic [12:0] rs, output logic rc, output logic ro,
                       output int lat);
      int j;
      @(negedge clk);
      i13.start = 1'b1; i13.sub = s; i13.a = av; i13.b = bv;
      @(negedge clk);
      j = 0;
      while (!i13.done && j < 40) begin
         i13.start = 1'b0; i13.a = 13'($urandom); i13.b = 13'($urandom);
         i13.sub = 1'($urandom);
         @(negedge clk);
         j++;
      end
      lat = j; rs = i13.sum; rc = i13.cout; ro = i13.ovf;
   endtask

   typedef struct {
      logic       s;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   initial begin
      vec_t        vecs[5];
      logic [7:0]  rs;
      logic [12:0] rs13;
      logic        rc, ro;
      logic [33:0] m;
      int          lat, nbusy, d1, d2, ndone, j;

      n_checks = 0; n_fail = 0;
      rst = 1'b1;
      i8.start = 1'b0;  i8.sub = 1'b0;  i8.a = '0;  i8.b = '0;
      i13.start = 1'b0; i13.sub = 1'b0; i13.a = '0; i13.b = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", i8.busy, 0);
      check("rst_done", i8.done, 0);
      check("rst_sum",  i8.sum,  0);
      check("rst_cout", i8.cout, 0);
      check("rst_ovf",  i8.ovf,  0);

      vecs[0] = '{1'b0, 8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
      foreach (vecs[i]) begin
         op8(vecs[i].s, vecs[i].a, vecs[i].b, -1, rs, rc, ro, lat, nbusy);
         check($sformatf("dir%0d_sum", i),  rs, vecs[i].sum);
         check($sformatf("dir%0d_cout", i), rc, vecs[i].cout);
         check($sformatf("dir%0d_ovf", i),  ro, vecs[i].ovf);
         check($sformatf("dir%0d_lat", i),  lat, 9);
         check($sformatf("dir%0d_busy", i), nbusy, 9);
         @(negedge clk);
         check($sformatf("dir%0d_done_pulse", i), i8.done, 0);
      end

      // start re-pulsed mid-operation must be ignored
      op8(1'b0, 8'h35, 8'h4A, 3, rs, rc, ro, lat, nbusy);
      check("glitch_sum", rs, 8'h7F);
      check("glitch_lat", lat, 9);
      @(negedge clk);
      check("glitch_idle_done", i8.done, 0);

      // start held high: ops back to back every WIDTH+2 cycles
      i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'h01; i8.b = 8'h02;
      d1 = -1; d2 = -1; j = 0;
      while (d2 < 0 && j < 60) begin
         @(negedge clk);
         j++;
         if (i8.done) begin
            check("held_sum", i8.sum, 8'h03);
            if (d1 < 0) d1 = j; else d2 = j;
         end
      end
      i8.start = 1'b0;
      check("held_first_done", d1, 10);
      check("held_spacing", d2 - d1, 10);
      repeat (2) @(negedge clk);

      // reset during RUN aborts without a done pulse
      @(negedge clk);
      i8.start = 1'b1; i8.sub = 1'b0; i8.a = 8'h35; i8.b = 8'h4A;
      @(negedge clk);
      i8.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", i8.busy, 0);
      check("abort_done", i8.done, 0);
      check("abort_sum",  i8.sum,  0);
      check("abort_cout", i8.cout, 0);
      check("abort_ovf",  i8.ovf,  0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (i8.done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      op8(1'b0, 8'h01, 8'h01, -1, rs, rc, ro, lat, nbusy);
      check("post_abort_sum", rs, 8'h02);
      check("post_abort_lat", lat, 9);

      // randomised against the reference model, with held-result checks
      for (int k = 0; k < 500; k++) begin
         logic       s;
         logic [7:0] av, bv;
         s = 1'($urandom); av = 8'($urandom); bv = 8'($urandom);
         op8(s, av, bv, -1, rs, rc, ro, lat, nbusy);
         m = model(8, s, {24'd0, av}, {24'd0, bv});
         check("rnd8_sum",  rs, m[31:0]);
         check("rnd8_cout", rc, m[32]);
         check("rnd8_ovf",  ro, m[33]);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("rnd8_hold", i8.sum, m[31:0]);
         end
      end

      for (int k = 0; k < 500; k++) begin
         logic        s;
         logic [12:0] av, bv;
         s = 1'($urandom); av = 13'($urandom); bv = 13'($urandom);
         op13(s, av, bv, rs13, rc, ro, lat);
         m = model(13, s, {19'd0, av}, {19'd0, bv});
         check("rnd13_sum",  rs13, m[31:0]);
         check("rnd13_cout", rc, m[32]);
         check("rnd13_ovf",  ro, m[33]);
         check("rnd13_lat",  lat, 14);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("rnd13_hold", i13.sum, m[31:0]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
